regfile_wr_arbiter: RTL and testbench

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

---
 rtl/regfile_wr_arbiter_pkg.sv | 19 +
 rtl/regfile_wr_arbiter_rr_arb2.sv | 38 +++
 rtl/regfile_wr_arbiter.sv | 70 +++++++
 tb/tb_regfile_wr_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared processor definitions for the register-file write path: default widths,
// the hardwired-zero register, and the requester index encoding.
package regfile_wr_arbiter_pkg;

    localparam int DEF_B    = 32;
    localparam int DEF_W    = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_t;

    // Writes aimed at the hardwired-zero register are accepted but never issued
    function automatic logic is_zero_reg(input logic [31:0] addr);
        return (addr == 32'(ZERO_REG));
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority pointer; the pointer only moves
// after a contested grant, so a lone requester never disturbs the fairness order.
module rr_arb2
    import regfile_wr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       freeze,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output req_idx_t   rr_ptr
);

    logic contested;

    assign contested = valid[0] && valid[1];

    always_comb begin
        grant = 2'b00;
        if (rst_n && !freeze) begin
            if (contested) begin
                grant[0] = (rr_ptr == REQ_ALU);
                grant[1] = (rr_ptr == REQ_MEM);
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= REQ_ALU;
        end else if (contested && !freeze) begin
            rr_ptr <= grant[0] ? REQ_MEM : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the ALU and load-unit writeback requests onto the single register-file
// write port through one registered output stage, and counts contention cycles.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_addr,
    input  logic [B-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_addr,
    input  logic [B-1:0] req1_data,
    output logic         req1_ready,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [B-1:0] w_data,
    output logic [15:0]  conflict_cnt
);

    logic [1:0]   grant;
    req_idx_t     rr_ptr;
    logic         transfer;
    logic [W-1:0] sel_addr;
    logic [B-1:0] sel_data;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (freeze),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant),
        .rr_ptr (rr_ptr)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign transfer   = grant[0] || grant[1];
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            wr_en <= transfer && !is_zero_reg(32'(sel_addr));
            if (transfer) begin
                w_addr <= sel_addr;
                w_data <= sel_data;
            end
        end
    end

    // Counts every edge that saw both requesters competing while not frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= 16'd0;
        end else if (req0_valid && req1_valid && !freeze && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations.
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        wr_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(.B(32), .W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wr_en        (wr_en),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        freeze     = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 5'd0;
        req0_data  = 32'h0;
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 32'h0;

        // Reset state, with both valids asserted to show readies stay low
        #2;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #10 rst_n = 1'b1;
        tick();

        // Single requester
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk("single_wr_en", 32'(wr_en), 32'd1);
        chk("single_w_addr", 32'(w_addr), 32'd3);
        chk("single_w_data", w_data, 32'hDEADBEEF);
        req0_valid = 1'b0;
        tick();
        chk("idle_wr_en", 32'(wr_en), 32'd0);
        chk("idle_hold_addr", 32'(w_addr), 32'd3);
        chk("idle_hold_data", w_data, 32'hDEADBEEF);

        // Contention: four cycles, pointer starts at req0
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hA0A0A0A0;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hB1B1B1B1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_ready1", 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("cont_wr_en", 32'(wr_en), 32'd1);
            chk("cont_w_addr", 32'(w_addr), (i % 2 == 0) ? 32'd4 : 32'd5);
            chk("cont_w_data", w_data, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            chk("cont_cnt", 32'(conflict_cnt), 32'(i + 1));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Zero register: accepted but not written
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1;
        #1;
        chk("zero_ready1", 32'(req1_ready), 32'd1);
        tick();
        chk("zero_wr_en", 32'(wr_en), 32'd0);
        chk("zero_cnt", 32'(conflict_cnt), 32'd4);

        // One contested grant to req0 moves the pointer to req1 (count 5)
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'hA0A0A0A0;
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'hB1B1B1B1;
        tick();
        chk("pre_frz_addr", 32'(w_addr), 32'd4);
        chk("pre_frz_cnt", 32'(conflict_cnt), 32'd5);

        // Freeze for three cycles with both valid
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_ready0", 32'(req0_ready), 32'd0);
            chk("frz_ready1", 32'(req1_ready), 32'd0);
            tick();
            chk("frz_wr_en", 32'(wr_en), 32'd0);
            chk("frz_cnt", 32'(conflict_cnt), 32'd5);
        end
        freeze = 1'b0;
        #1;
        chk("unfrz_ready0", 32'(req0_ready), 32'd0);
        chk("unfrz_ready1", 32'(req1_ready), 32'd1);
        tick();
        chk("unfrz_w_addr", 32'(w_addr), 32'd5);
        chk("unfrz_cnt", 32'(conflict_cnt), 32'd6);

        // Same nonzero address: req0 (pointer holder) first, then req1 wins the register
        req0_addr = 5'd7; req0_data = 32'h11110000;
        req1_addr = 5'd7; req1_data = 32'h22220000;
        tick();
        chk("same_first_data", w_data, 32'h11110000);
        req0_valid = 1'b0;
        tick();
        chk("same_second_wr_en", 32'(wr_en), 32'd1);
        chk("same_second_data", w_data, 32'h22220000);
        chk("same_cnt", 32'(conflict_cnt), 32'd7);

        // Reset mid-write: pointer is at req1 here, reset must return it to req0
        req1_addr = 5'd9; req1_data = 32'h99;
        tick();
        chk("mid_pre_wr_en", 32'(wr_en), 32'd1);
        req1_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_wr_en", 32'(wr_en), 32'd0);
        chk("mid_cnt", 32'(conflict_cnt), 32'd0);
        chk("mid_w_addr", 32'(w_addr), 32'd0);
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAAAA;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBBBB;
        #1;
        chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
        #3 rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(req1_ready), 32'd0);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        tick();
        chk("post_rst_w_addr", 32'(w_addr), 32'd10);
        chk("post_rst_w_data", w_data, 32'hAAAA);

        // Saturation: restart the count, then drive 70000 contention cycles
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(conflict_cnt), 32'h0000FFFE);
        tick();
        chk("sat_ffff", 32'(conflict_cnt), 32'h0000FFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        chk("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
